// File: rtl/branch_predictor.sv
// Dual-lane bimodal branch predictor: 64-entry table of 2-bit saturating counters
// indexed by PC[7:2], with saturating branch and mispredict counters.
module branch_predictor (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] PC1F,
   input  logic [31:0] PC2F,
   output logic        Prediction1F,
   output logic        Prediction2F,
   input  logic [31:0] PC1E,
   input  logic [31:0] PC2E,
   input  logic        Branch1E,
   input  logic        Branch2E,
   input  logic        Taken1E,
   input  logic        Taken2E,
   input  logic        Prediction1E,
   input  logic        Prediction2E,
   input  logic        Stall1E,
   input  logic        Stall2E,
   output logic [31:0] BranchCount,
   output logic [31:0] MispredictCount
);

   localparam int unsigned ENTRIES = 64;

   logic [1:0]  pht_q [ENTRIES];
   logic [1:0]  pht_d [ENTRIES];
   logic [5:0]  idx1e;
   logic [5:0]  idx2e;
   logic        lane1_mispredict;
   logic        en1;
   logic        en2;
   logic        miss1;
   logic        miss2;
   logic [1:0]  n_upd;
   logic [1:0]  n_miss;
   logic [31:0] branch_cnt_q;
   logic [31:0] mispredict_cnt_q;
   logic        unused_pc_bits;

   function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
      if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
      return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] base, input logic [1:0] inc);
      logic [32:0] sum;
      sum = {1'b0, base} + {31'd0, inc};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

   assign idx1e = PC1E[7:2];
   assign idx2e = PC2E[7:2];

   // Lookups read the current table, so a same-cycle write shows up next cycle.
   assign Prediction1F = pht_q[PC1F[7:2]][1];
   assign Prediction2F = pht_q[PC2F[7:2]][1];

   // A lane 1 mispredict squashes lane 2 as wrong-path, stalled or not.
   assign lane1_mispredict = Branch1E & (Prediction1E != Taken1E);
   assign en1   = Branch1E & ~Stall1E;
   assign en2   = Branch2E & ~Stall2E & ~lane1_mispredict;
   assign miss1 = en1 & (Prediction1E != Taken1E);
   assign miss2 = en2 & (Prediction2E != Taken2E);

   assign n_upd  = {1'b0, en1} + {1'b0, en2};
   assign n_miss = {1'b0, miss1} + {1'b0, miss2};

   // Lane 2 steps from lane 1's result so same-index updates chain in order.
   always_comb begin
      pht_d = pht_q;
      if (en1) pht_d[idx1e] = sat_step(pht_d[idx1e], Taken1E);
      if (en2) pht_d[idx2e] = sat_step(pht_d[idx2e], Taken2E);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b01;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         pht_q            <= pht_d;
         branch_cnt_q     <= sat_add(branch_cnt_q, n_upd);
         mispredict_cnt_q <= sat_add(mispredict_cnt_q, n_miss);
      end
   end

   assign BranchCount     = branch_cnt_q;
   assign MispredictCount = mispredict_cnt_q;

   assign unused_pc_bits = ^{PC1F[31:8], PC1F[1:0], PC2F[31:8], PC2F[1:0],
                             PC1E[31:8], PC1E[1:0], PC2E[31:8], PC2E[1:0]};

endmodule
